// File: rtl/overture_decode_stage.sv
// Overture instruction-decode stage.
// Decodes each accepted opcode into a class and its operand fields, holds up to
// two decoded entries so that execute can stall without a combinational ready
// path back to fetch, and counts retired instructions per class with saturation.
//
// Occupancy state | meaning
// ----------------+-------------------------------------------------
// OCC_EMPTY       | no entry held; out_valid low, fetch may send
// OCC_ONE         | head entry held; out_valid high, fetch may send
// OCC_FULL        | head and tail held; in_ready low next cycle
module overture_decode_stage #(
  parameter int FIELD_W = 3,
  parameter int IO_REG  = 6,
  parameter int CNT_W   = 16,
  localparam int OPW    = 2 + 2 * FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [OPW-1:0]       in_opcode,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_class,
  output logic [2*FIELD_W-1:0] out_imm,
  output logic [FIELD_W-1:0]   out_src,
  output logic [FIELD_W-1:0]   out_dst,
  output logic                 out_illegal,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_imm,
  output logic [CNT_W-1:0]     cnt_calc,
  output logic [CNT_W-1:0]     cnt_copy,
  output logic [CNT_W-1:0]     cnt_cond
);

  localparam logic [FIELD_W-1:0] IO_IDX  = FIELD_W'(IO_REG);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CALC = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  // One decoded instruction; the raw opcode is never kept.
  typedef struct packed {
    logic [3:0]           cls;
    logic [2*FIELD_W-1:0] imm;
    logic [FIELD_W-1:0]   src;
    logic [FIELD_W-1:0]   dst;
    logic                 illegal;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t   state;
  occ_t   state_nxt;
  entry_t dec;
  entry_t head;
  entry_t tail;
  logic   accept;
  logic   retire;
  logic   head_we;
  logic   head_from_tail;
  logic   tail_we;

  logic [CNT_W-1:0] cnt_q [4];

  assign out_valid = (state != OCC_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign retire    = out_valid & out_ready & ~flush;

  // Decode the incoming opcode; only these fields are stored.
  always_comb begin
    dec         = '0;
    dec.imm     = in_opcode[2*FIELD_W-1:0];
    dec.src     = in_opcode[2*FIELD_W-1:FIELD_W];
    dec.dst     = in_opcode[FIELD_W-1:0];
    case (in_opcode[OPW-1:OPW-2])
      CLS_IMM:  dec.cls = 4'b0001;
      CLS_CALC: dec.cls = 4'b0010;
      CLS_COPY: dec.cls = 4'b0100;
      CLS_COND: dec.cls = 4'b1000;
      default:  dec.cls = 4'b0000;
    endcase
    dec.illegal = (in_opcode[OPW-1:OPW-2] == CLS_COPY) &&
                  (in_opcode[2*FIELD_W-1:FIELD_W] == IO_IDX) &&
                  (in_opcode[FIELD_W-1:0] == IO_IDX);
  end

  // Occupancy next-state and entry write enables; flush empties the buffer.
  always_comb begin
    state_nxt      = state;
    head_we        = 1'b0;
    head_from_tail = 1'b0;
    tail_we        = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            head_we   = 1'b1;
            state_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && retire) begin
            // The only entry leaves, so the new one becomes head directly.
            head_we = 1'b1;
          end else if (accept) begin
            tail_we   = 1'b1;
            state_nxt = OCC_FULL;
          end else if (retire) begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so no accept can coincide with this retire.
          if (retire) begin
            head_we        = 1'b1;
            head_from_tail = 1'b1;
            state_nxt      = OCC_ONE;
          end
        end
        default: begin
          state_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register and registered in_ready derived from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OCC_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != OCC_FULL);
    end
  end

  // Head entry storage; it keeps its last value once the buffer drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (head_we) begin
      head <= head_from_tail ? tail : dec;
    end
  end

  // Tail entry storage, written only when a second entry arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
    end else if (tail_we) begin
      tail <= dec;
    end
  end

  assign out_class   = head.cls;
  assign out_imm     = head.imm;
  assign out_src     = head.src;
  assign out_dst     = head.dst;
  assign out_illegal = head.illegal;

  // Per-class saturating retirement counters; clear wins over a same-cycle retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (retire) begin
      for (int i = 0; i < 4; i++) begin
        if (head.cls[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_imm  = cnt_q[0];
  assign cnt_calc = cnt_q[1];
  assign cnt_copy = cnt_q[2];
  assign cnt_cond = cnt_q[3];

endmodule

// File: tb/tb_overture_decode_stage.sv
// Testbench for overture_decode_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model.
module tb_overture_decode_stage;

  localparam int FIELD_W = 3;
  localparam int IO_REG  = 6;
  localparam int CNT_W   = 2;
  localparam int OPW     = 2 + 2 * FIELD_W;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [OPW-1:0]       in_opcode = '0;
  logic                 in_ready;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [3:0]           out_class;
  logic [2*FIELD_W-1:0] out_imm;
  logic [FIELD_W-1:0]   out_src;
  logic [FIELD_W-1:0]   out_dst;
  logic                 out_illegal;
  logic                 cnt_clr = 1'b0;
  logic [CNT_W-1:0]     cnt_imm;
  logic [CNT_W-1:0]     cnt_calc;
  logic [CNT_W-1:0]     cnt_copy;
  logic [CNT_W-1:0]     cnt_cond;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  overture_decode_stage #(
    .FIELD_W(FIELD_W),
    .IO_REG (IO_REG),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_imm    (out_imm),
    .out_src    (out_src),
    .out_dst    (out_dst),
    .out_illegal(out_illegal),
    .cnt_clr    (cnt_clr),
    .cnt_imm    (cnt_imm),
    .cnt_calc   (cnt_calc),
    .cnt_copy   (cnt_copy),
    .cnt_cond   (cnt_cond)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: raw opcodes in a queue, counts per class index.
  logic [OPW-1:0] mq [$];
  int             m_cnt [4];
  bit             m_rdy;
  bit             m_acc;
  bit             m_ret;
  logic [OPW-1:0] m_head;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rdy = 1'b1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_acc = in_valid && m_rdy && !flush;
      m_ret = (mq.size() != 0) && out_ready && !flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ret) begin
          m_head = mq.pop_front();
          if (!cnt_clr && m_cnt[m_head[OPW-1:OPW-2]] < CMAX)
            m_cnt[m_head[OPW-1:OPW-2]] = m_cnt[m_head[OPW-1:OPW-2]] + 1;
        end
        if (m_acc) mq.push_back(in_opcode);
      end
      if (cnt_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_rdy = (mq.size() < 2);
    end
  end

  // Compare DUT against the model on every falling edge.
  logic [OPW-1:0] c_op;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("in_ready", 32'(in_ready), 32'(m_rdy));
      if (mq.size() != 0) begin
        c_op = mq[0];
        check("out_class", 32'(out_class), 32'(4'b0001 << c_op[OPW-1:OPW-2]));
        check("out_imm", 32'(out_imm), 32'(c_op[2*FIELD_W-1:0]));
        check("out_src", 32'(out_src), 32'(c_op[2*FIELD_W-1:FIELD_W]));
        check("out_dst", 32'(out_dst), 32'(c_op[FIELD_W-1:0]));
        check("out_illegal", 32'(out_illegal),
              32'(c_op[OPW-1:OPW-2] == 2'b10 && c_op[2*FIELD_W-1:FIELD_W] == IO_REG &&
                  c_op[FIELD_W-1:0] == IO_REG));
      end
      check("cnt_imm", 32'(cnt_imm), 32'(m_cnt[0]));
      check("cnt_calc", 32'(cnt_calc), 32'(m_cnt[1]));
      check("cnt_copy", 32'(cnt_copy), 32'(m_cnt[2]));
      check("cnt_cond", 32'(cnt_cond), 32'(m_cnt[3]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_cnts(input string name, input int ci, input int cc, input int cp, input int cd);
    check({name, "_imm"}, 32'(cnt_imm), 32'(ci));
    check({name, "_calc"}, 32'(cnt_calc), 32'(cc));
    check({name, "_copy"}, 32'(cnt_copy), 32'(cp));
    check({name, "_cond"}, 32'(cnt_cond), 32'(cd));
  endtask

  initial begin
    // Reset then idle.
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fields", 32'({out_class, out_imm, out_src, out_dst, out_illegal}), 32'd0);
    check_cnts("rst_cnt", 0, 0, 0, 0);
    cyc();

    // Single decode of 0x8E.
    in_valid = 1'b1; in_opcode = 8'h8E; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_class", 32'(out_class), 32'h4);
    check("single_src", 32'(out_src), 32'd1);
    check("single_dst", 32'(out_dst), 32'd6);
    check("single_illegal", 32'(out_illegal), 32'd0);
    cyc();
    check("single_cnt_copy", 32'(cnt_copy), 32'd1);
    check("single_drained", 32'(out_valid), 32'd0);

    // Backpressure: 0x05, 0x43 fill the buffer, 0xC4 is held off.
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h05;
    cyc();
    in_opcode = 8'h43;
    cyc();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    in_opcode = 8'hC4;
    cyc();
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_head_class", 32'(out_class), 32'h1);
    check("bp_head_imm", 32'(out_imm), 32'd5);
    out_ready = 1'b1;
    cyc();
    check("bp_second_class", 32'(out_class), 32'h2);
    check("bp_second_dst", 32'(out_dst), 32'd3);
    cyc();
    in_valid = 1'b0;
    check("bp_third_class", 32'(out_class), 32'h8);
    check("bp_third_dst", 32'(out_dst), 32'd4);
    cyc();
    check("bp_empty", 32'(out_valid), 32'd0);
    check_cnts("bp_cnt", 1, 1, 1, 1);

    // Illegal I/O copy.
    in_valid = 1'b1; in_opcode = 8'hB6;
    cyc();
    in_valid = 1'b0;
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_class", 32'(out_class), 32'h4);
    cyc();
    check("ill_cnt_copy", 32'(cnt_copy), 32'd2);

    // Flush with a full buffer and a same-cycle input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h05;
    cyc();
    in_opcode = 8'h43;
    cyc();
    flush = 1'b1; in_opcode = 8'h8E;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check_cnts("flush_cnt", 1, 1, 2, 1);
    cyc();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Saturation then clear together with a retire.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_opcode = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("sat_cnt_imm", 32'(cnt_imm), 32'(CMAX));
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h07;
    cyc();
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check_cnts("clr_cnt", 0, 0, 0, 0);
    check("clr_retired", 32'(out_valid), 32'd0);

    // Reset mid-transfer with two entries held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 8'h41;
    cyc();
    in_opcode = 8'hC2;
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = ($urandom_range(0, 7) == 0) ? 8'hB6 : 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/overture_decode_stage.md
Name: overture_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the Overture datapath. Sits between instruction fetch and execute.
- Classifies each opcode by its top two bits: IMMEDIATE, CALCULATION, COPY or CONDITION.
- Extracts the operand fields and flags illegal I/O copies.
- Buffers up to two decoded instructions so execute can stall without a combinational ready path back to fetch. Keeps saturating per-class retirement counters for debug.

Parameters:
- FIELD_W, 3: operand field width; opcode width OPW = 2 + 2*FIELD_W (default 8).
- IO_REG, 6: register index that is the I/O port; a copy with src == dst == IO_REG is illegal.
- CNT_W, 16: width of each per-class retirement counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an opcode.
- in_opcode  in  OPW  raw instruction.
- in_ready  out  1  stage can accept; registered, equals "fewer than 2 entries held".
- flush  in  1  discard all held and incoming instructions (branch taken).
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_class  out  4  one-hot {CONDITION, COPY, CALCULATION, IMMEDIATE}, bit0 = IMMEDIATE.
- out_imm  out  2*FIELD_W  low 2*FIELD_W opcode bits (immediate value).
- out_src  out  FIELD_W  opcode[2*FIELD_W-1:FIELD_W].
- out_dst  out  FIELD_W  opcode[FIELD_W-1:0]; also the ALU op and condition code.
- out_illegal  out  1  head is COPY with src == dst == IO_REG.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_imm, cnt_calc, cnt_copy, cnt_cond  out  CNT_W each  retired instructions per class.

Behaviour:
- Reset (async, immediate on rst high):
  - both buffer entries invalid;
  - out_valid = 0, in_ready = 1;
  - out_class, out_imm, out_src, out_dst and out_illegal = 0;
  - all counters = 0.
- Decode rule:
  - class index = opcode[OPW-1:OPW-2]: 00 IMMEDIATE, 01 CALCULATION, 10 COPY, 11 CONDITION.
  - Decode happens combinationally at acceptance; decoded fields are stored in the buffer, never the raw opcode.
- Accept = in_valid & in_ready & !flush. Retire = out_valid & out_ready & !flush.
- Buffer: 2-entry FIFO; head drives the out_* fields.
  - Empty + accept: entry becomes head; out_valid = 1 next cycle (latency 1).
  - Accept and retire in the same cycle: occupancy unchanged; the new entry goes behind the remaining one. With occupancy 1, the new entry becomes head next cycle.
  - Occupancy 2: in_ready = 0 next cycle; in_valid is ignored while in_ready = 0.
  - in_ready is a registered function of the next occupancy, with no combinational path from out_ready.
- Outputs are held stable while out_valid & !out_ready. When out_valid = 0, the out_* fields show the last value; do not care.
- Flush:
  - all entries are invalidated at the next edge;
  - the same-cycle input is dropped and no retire is counted;
  - next cycle out_valid = 0 and in_ready = 1;
  - flush has priority over accept, retire and cnt_clr ordering (see below).
- Counters:
  - on retire, the counter matching out_class increments by 1 and saturates at 2^CNT_W-1;
  - cnt_clr zeroes all counters next edge, and any same-cycle increment is lost;
  - flush does not clear counters.
- Illegal copy: still decoded, buffered and retired normally, and counted in cnt_copy. out_illegal is only a flag; execute decides the action.
- rst asserted mid-transfer: the held entries are lost and no partial retire is counted.

Test Plan:
- Reset then idle: rst pulse with clk running -> out_valid=0, in_ready=1, all counters 0, out fields 0.
- Single decode: 0x8E (COPY, src=1, dst=6) with out_ready=1 -> next cycle out_valid=1, out_class=0100, out_src=1, out_dst=6, out_illegal=0; one cycle later cnt_copy=1.
- Backpressure: out_ready=0, stream 0x05, 0x43, 0xC4 -> 0x05 and 0x43 accepted, then in_ready=0 and 0xC4 is held off. Release out_ready -> retire order 0x05 (class 0001, imm=5), 0x43 (class 0010, dst=3), 0xC4 (class 1000, dst=4). Each counter counts only its own class.
- Illegal I/O copy: 0xB6 (src=6, dst=6) -> out_illegal=1, out_class=0100, cnt_copy increments.
- Flush with full buffer and in_valid=1: assert flush one cycle -> next cycle out_valid=0, in_ready=1, the incoming opcode is dropped and counters are unchanged.
- Saturation and clear with CNT_W=2: retire five IMMEDIATE instructions -> cnt_imm=3. Assert cnt_clr together with a retire -> cnt_imm=0.
